level_sensor_conditioner: RTL and testbench

Upstream front-end for the reservoir level FSM. It takes the three raw float-switch inputs and synchronises and debounces each one. It then checks that the debounced vector is a legal thermometer code and drives the clean s[3:1] bus that the level FSM consumes. A supervisory fault flag and a level-change strobe are also provided for the control panel.

---
 rtl/level_sensor_conditioner.sv | 150 +++++++++++++++
 tb/tb_level_sensor_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/level_sensor_conditioner.sv
// Float-switch front-end: 2-flop sync, per-bit debounce, thermometer-code
// check with last-legal hold, and a supervisory fault FSM for the panel.
`timescale 1ns/1ps
module level_sensor_conditioner #(
   parameter int unsigned DB_CYCLES    = 4,
   parameter int unsigned FAULT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:1] raw,
   output logic [3:1] s,
   output logic       fault,
   output logic       chg
);

   localparam logic [7:0] DB_LIM    = 8'(DB_CYCLES);
   localparam logic [7:0] FAULT_LIM = 8'(FAULT_CYCLES);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2,
      ST_RECOVER = 2'd3
   } sup_state_t;

   logic [3:1] meta;
   logic [3:1] sync;
   logic [3:1] deb;
   logic [7:0] cnt [3:1];
   logic       legal;

   sup_state_t state, state_nxt;
   logic [7:0] fcnt, fcnt_nxt;

   function automatic logic is_legal(input logic [3:1] code);
      return code inside {3'b000, 3'b001, 3'b011, 3'b111};
   endfunction

   // NOTE: every register uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // Each bit debounces independently; a mismatch must persist DB_CYCLES clocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb <= '0;
         for (int i = 1; i <= 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 1; i <= 3; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] >= DB_LIM - 8'd1) begin
               deb[i] <= sync[i];
               cnt[i] <= '0;
            end else if (cnt[i] != 8'hff) begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign legal = is_legal(deb);

   // Illegal codes are dropped so the level FSM never sees a false "empty".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s   <= '0;
         chg <= 1'b0;
      end else begin
         chg <= legal && (deb != s);
         if (legal) s <= deb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_OK;
         fcnt  <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         fault <= (state_nxt == ST_FAULT) || (state_nxt == ST_RECOVER);
      end
   end

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      unique case (state)
         ST_OK: begin
            if (!legal) begin
               if (FAULT_LIM <= 8'd1) begin
                  state_nxt = ST_FAULT;
                  fcnt_nxt  = '0;
               end else begin
                  state_nxt = ST_SUSPECT;
                  fcnt_nxt  = 8'd1;
               end
            end
         end
         ST_SUSPECT: begin
            if (legal) begin
               state_nxt = ST_OK;
               fcnt_nxt  = '0;
            end else if (fcnt >= FAULT_LIM - 8'd1) begin
               state_nxt = ST_FAULT;
               fcnt_nxt  = '0;
            end else if (fcnt != 8'hff) begin
               fcnt_nxt = fcnt + 8'd1;
            end
         end
         ST_FAULT: begin
            if (legal) begin
               if (FAULT_LIM <= 8'd1) begin
                  state_nxt = ST_OK;
                  fcnt_nxt  = '0;
               end else begin
                  state_nxt = ST_RECOVER;
                  fcnt_nxt  = 8'd1;
               end
            end
         end
         ST_RECOVER: begin
            if (!legal) begin
               state_nxt = ST_FAULT;
               fcnt_nxt  = '0;
            end else if (fcnt >= FAULT_LIM - 8'd1) begin
               state_nxt = ST_OK;
               fcnt_nxt  = '0;
            end else if (fcnt != 8'hff) begin
               fcnt_nxt = fcnt + 8'd1;
            end
         end
         default: begin
            state_nxt = ST_OK;
            fcnt_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner: edge-exact expectations for
// debounce latency, illegal-code hold, fault entry/exit and async reset.
`timescale 1ns/1ps
module tb_level_sensor_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:1] raw;
   logic [3:1] s;
   logic       fault;
   logic       chg;

   int n_cmp = 0;
   int n_err = 0;
   int chg_count = 0;
   bit fault_seen = 1'b0;

   level_sensor_conditioner #(.DB_CYCLES(4), .FAULT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .raw   (raw),
      .s     (s),
      .fault (fault),
      .chg   (chg)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chg) chg_count++;
      if (fault) fault_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:1] seq [6];
      logic [3:1] prev;
      seq = '{3'b001, 3'b011, 3'b111, 3'b011, 3'b001, 3'b000};

      // Reset state
      reset = 1'b1;
      raw   = 3'b000;
      tick(2);
      check("rst_s", s, 0);
      check("rst_fault", fault, 0);
      check("rst_chg", chg, 0);
      reset = 1'b0;

      // 1. Clean step: s changes on edge 7 counting the first-sample edge as 1
      chg_count = 0; fault_seen = 1'b0;
      raw = 3'b001;
      tick(6);
      check("t1_s_before", s, 3'b000);
      check("t1_chg_before", chg, 0);
      tick(1);
      check("t1_s_after", s, 3'b001);
      check("t1_chg_pulse", chg, 1);
      tick(1);
      check("t1_chg_drop", chg, 0);
      tick(12);
      check("t1_chg_count", 8'(chg_count), 1);
      check("t1_fault_seen", fault_seen, 0);

      // 2. Glitch rejection, then a 4-cycle pulse that passes
      raw = 3'b000;
      tick(12);
      check("t2_start_s", s, 3'b000);
      chg_count = 0;
      raw = 3'b001;
      tick(3);
      raw = 3'b000;
      tick(15);
      check("t2_glitch_s", s, 3'b000);
      check("t2_glitch_chg", 8'(chg_count), 0);
      raw = 3'b001;
      tick(4);
      raw = 3'b000;
      tick(3);
      check("t2_pulse4_s", s, 3'b001);
      check("t2_pulse4_chg", chg, 1);
      tick(20);
      check("t2_back_s", s, 3'b000);

      // 3. Fill and drain
      fault_seen = 1'b0;
      prev = 3'b000;
      for (int k = 0; k < 6; k++) begin
         if (k == 1) chg_count = 0;
         raw = seq[k];
         tick(6);
         check("t3_lag_s", s, prev);
         tick(1);
         check("t3_new_s", s, seq[k]);
         check("t3_chg", chg, 1);
         tick(5);
         prev = seq[k];
      end
      check("t3_chg_count", 8'(chg_count), 5);
      check("t3_fault_seen", fault_seen, 0);

      // 4. Persistent fault and recovery
      raw = 3'b001;
      tick(12);
      chg_count = 0;
      raw = 3'b101;
      tick(6);
      check("t4_hold_s", s, 3'b001);
      tick(15);
      check("t4_fault_pre", fault, 0);
      tick(1);
      check("t4_fault_rise", fault, 1);
      check("t4_fault_s", s, 3'b001);
      tick(18);
      check("t4_hold_s_end", s, 3'b001);
      check("t4_no_chg", 8'(chg_count), 0);
      raw = 3'b011;
      tick(7);
      check("t4_rec_s", s, 3'b011);
      check("t4_rec_chg", chg, 1);
      check("t4_rec_fault", fault, 1);
      tick(14);
      check("t4_fault_pre_clr", fault, 1);
      tick(1);
      check("t4_fault_clr", fault, 0);
      tick(4);

      // 5. Transient illegal code
      chg_count = 0; fault_seen = 1'b0;
      raw = 3'b010;
      tick(10);
      raw = 3'b011;
      tick(6);
      check("t5_s", s, 3'b011);
      tick(4);
      check("t5_state", dut.state, 0);
      tick(10);
      check("t5_fault_seen", fault_seen, 0);
      check("t5_chg_count", 8'(chg_count), 0);
      check("t5_s_end", s, 3'b011);

      // 6. Async reset while in RECOVER with s=111
      raw = 3'b101;
      tick(30);
      check("t6_fault", fault, 1);
      raw = 3'b111;
      tick(7);
      check("t6_s_111", s, 3'b111);
      tick(3);
      check("t6_state_rec", dut.state, 3);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_s", s, 3'b000);
      check("t6_rst_fault", fault, 0);
      check("t6_rst_chg", chg, 0);
      check("t6_rst_state", dut.state, 0);
      tick(2);
      reset = 1'b0;
      tick(6);
      check("t6_redeb_before", s, 3'b000);
      tick(1);
      check("t6_redeb_s", s, 3'b111);
      check("t6_redeb_chg", chg, 1);
      check("t6_redeb_fault", fault, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
